rf_writeback_queue: RTL and testbench

Write-side companion of the register file: collects destination-register results from the ALU path and the load path, serializes them into the single register-file write port (RegWEn/AddrD/DataD), and forwards pending results to operand reads so that queued writes are never invisible. It sits between the EX/MEM result buses and the register file in the pipeline. It also exposes a per-register busy scoreboard to hazard logic.

---
 rtl/rf_writeback_queue.sv | 120 ++++++++++++
 tb/tb_rf_writeback_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_queue.sv
// Register-file write-back queue: merges ALU and load results into the single
// write port, forwards pending values to operand reads and drives the busy map.
module rf_writeback_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [4:0]                 alu_rd,
    input  logic [XLEN-1:0]            alu_data,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [4:0]                 ld_rd,
    input  logic [XLEN-1:0]            ld_data,
    output logic                       RegWEn,
    output logic [4:0]                 AddrD,
    output logic [XLEN-1:0]            DataD,
    input  logic [4:0]                 rs1_addr,
    input  logic [4:0]                 rs2_addr,
    output logic                       rs1_fwd_hit,
    output logic                       rs2_fwd_hit,
    output logic [XLEN-1:0]            rs1_fwd_data,
    output logic [XLEN-1:0]            rs2_fwd_data,
    output logic [31:0]                busy,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   free;
    logic            pop;
    logic            ld_push;
    logic            alu_push;
    logic [PW-1:0]   alu_slot;

    // Admission: free slots come from the start-of-cycle count; ALU owns the last slot.
    always_comb begin
        free      = CW'(DEPTH) - count;
        alu_ready = !reset && (free >= CW'(1));
        ld_ready  = !reset && ((free >= CW'(2)) || ((free >= CW'(1)) && !alu_valid));
        ld_push   = ld_valid && ld_ready && (ld_rd != 5'd0);
        alu_push  = alu_valid && alu_ready && (alu_rd != 5'd0);
        alu_slot  = tail + PW'(ld_push);
        pop       = (count != CW'(0));
    end

    // Write port is driven straight from the head entry.
    always_comb begin
        RegWEn = !reset && (count != CW'(0));
        AddrD  = '0;
        DataD  = '0;
        if (RegWEn) begin
            AddrD = mem[head].rd;
            DataD = mem[head].data;
        end
    end

    // Walk entries oldest to youngest so the last match wins the forward mux.
    always_comb begin
        logic [PW-1:0] idx;
        idx          = '0;
        rs1_fwd_hit  = 1'b0;
        rs2_fwd_hit  = 1'b0;
        rs1_fwd_data = '0;
        rs2_fwd_data = '0;
        busy         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (!reset && (CW'(i) < count)) begin
                busy[mem[idx].rd] = 1'b1;
                if ((rs1_addr != 5'd0) && (mem[idx].rd == rs1_addr)) begin
                    rs1_fwd_hit  = 1'b1;
                    rs1_fwd_data = mem[idx].data;
                end
                if ((rs2_addr != 5'd0) && (mem[idx].rd == rs2_addr)) begin
                    rs2_fwd_hit  = 1'b1;
                    rs2_fwd_data = mem[idx].data;
                end
            end
        end
        busy[0] = 1'b0;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                head <= head + PW'(1);
            end
            tail  <= tail + PW'(ld_push) + PW'(alu_push);
            count <= count + CW'(ld_push) + CW'(alu_push) - CW'(pop);
        end
    end

    // Entry storage; the load is older than a same-cycle ALU result.
    always_ff @(posedge clk) begin
        if (ld_push) begin
            mem[tail] <= '{rd: ld_rd, data: ld_data};
        end
        if (alu_push) begin
            mem[alu_slot] <= '{rd: alu_rd, data: alu_data};
        end
    end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Scoreboard bench for rf_writeback_queue: accepted results are queued in
// program order and compared against the write port, forwarding and busy map.
module tb_rf_writeback_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            alu_valid, ld_valid;
    logic            alu_ready, ld_ready;
    logic [4:0]      alu_rd, ld_rd;
    logic [XLEN-1:0] alu_data, ld_data;
    logic            RegWEn;
    logic [4:0]      AddrD;
    logic [XLEN-1:0] DataD;
    logic [4:0]      rs1_addr, rs2_addr;
    logic            rs1_fwd_hit, rs2_fwd_hit;
    logic [XLEN-1:0] rs1_fwd_data, rs2_fwd_data;
    logic [31:0]     busy;
    logic [2:0]      count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t sb[$];

    always #5 clk = ~clk;

    rf_writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .RegWEn(RegWEn), .AddrD(AddrD), .DataD(DataD),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_fwd_hit(rs1_fwd_hit), .rs2_fwd_hit(rs2_fwd_hit),
        .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data),
        .busy(busy), .count(count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_fwd(input logic [4:0] a, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != 5'd0) begin
            foreach (sb[i]) begin
                if (sb[i].rd == a) begin
                    hit = 1'b1;
                    d   = sb[i].data;
                end
            end
        end
    endfunction

    // One clock: compare at the falling edge, update the scoreboard at the rising edge.
    task automatic step();
        int          fr;
        logic        ea, el, h;
        logic [31:0] d, b;
        @(negedge clk);
        fr = int'(DEPTH) - sb.size();
        ea = !reset && (fr >= 1);
        el = !reset && ((fr >= 2) || ((fr >= 1) && !alu_valid));
        check("alu_ready", 32'(alu_ready), 32'(ea));
        check("ld_ready", 32'(ld_ready), 32'(el));
        check("count", 32'(count), 32'(sb.size()));
        if (!reset && sb.size() != 0) begin
            check("RegWEn", 32'(RegWEn), 32'd1);
            check("AddrD", 32'(AddrD), 32'(sb[0].rd));
            check("DataD", DataD, sb[0].data);
        end else begin
            check("RegWEn", 32'(RegWEn), 32'd0);
            check("AddrD", 32'(AddrD), 32'd0);
            check("DataD", DataD, 32'd0);
        end
        model_fwd(rs1_addr, h, d);
        if (reset) begin h = 1'b0; d = '0; end
        check("rs1_fwd_hit", 32'(rs1_fwd_hit), 32'(h));
        check("rs1_fwd_data", rs1_fwd_data, d);
        model_fwd(rs2_addr, h, d);
        if (reset) begin h = 1'b0; d = '0; end
        check("rs2_fwd_hit", 32'(rs2_fwd_hit), 32'(h));
        check("rs2_fwd_data", rs2_fwd_data, d);
        b = '0;
        if (!reset) foreach (sb[i]) b[sb[i].rd] = 1'b1;
        b[0] = 1'b0;
        check("busy", busy, b);
        @(posedge clk);
        if (reset) begin
            sb.delete();
        end else begin
            if (sb.size() != 0) void'(sb.pop_front());
            if (ld_valid && el && ld_rd != 5'd0) sb.push_back('{rd: ld_rd, data: ld_data});
            if (alu_valid && ea && alu_rd != 5'd0) sb.push_back('{rd: alu_rd, data: alu_data});
        end
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        alu_rd = '0; alu_data = '0; ld_rd = '0; ld_data = '0;
        rs1_addr = '0; rs2_addr = '0;
        @(posedge clk);
        #1;
        step();
        reset = 1'b0;
        step();

        // Single ALU result to x5, observed on rs1.
        rs1_addr = 5'd5;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_00AA;
        step();
        idle();
        step();
        step();

        // Load and ALU to the same rd in one cycle.
        rs2_addr = 5'd3;
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h11;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h22;
        step();
        idle();
        repeat (3) step();

        // x0 results are accepted and dropped.
        rs1_addr = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
        step();
        idle();
        step();

        // Sustained dual-issue fills the queue.
        for (int i = 0; i < 12; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(1 + (i % 31)); alu_data = 32'hA000_0000 + 32'(i);
            ld_valid  = 1'b1; ld_rd  = 5'(16 + (i % 15)); ld_data = 32'hB000_0000 + 32'(i);
            rs1_addr = alu_rd; rs2_addr = ld_rd;
            step();
        end
        idle();
        repeat (5) step();

        // Three entries queued, then reset discards them.
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        ld_valid  = 1'b1; ld_rd  = 5'd8; ld_data  = 32'h88;
        step();
        alu_rd = 5'd9; alu_data = 32'h99; ld_rd = 5'd10; ld_data = 32'h1010;
        rs1_addr = 5'd9; rs2_addr = 5'd10;
        step();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (3) step();

        // Pointer wrap with distinct registers.
        for (int r = 1; r <= 10; r++) begin
            alu_valid = 1'b1; alu_rd = 5'(r); alu_data = 32'(r) * 32'h101;
            rs1_addr = 5'(r); rs2_addr = 5'(r > 1 ? r - 1 : 1);
            step();
        end
        idle();
        repeat (3) step();

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            alu_valid = 1'($urandom_range(0, 1));
            ld_valid  = 1'($urandom_range(0, 1));
            alu_rd    = 5'($urandom_range(0, 7));
            ld_rd     = 5'($urandom_range(0, 7));
            alu_data  = $urandom;
            ld_data   = $urandom;
            rs1_addr  = 5'($urandom_range(0, 7));
            rs2_addr  = 5'($urandom_range(0, 7));
            reset     = ($urandom_range(0, 49) == 0);
            step();
        end
        reset = 1'b0;
        idle();
        repeat (6) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
